alu_arbiter: RTL and testbench

- Shares one combinational ALU (4-bit select, M-bit operands) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration, registered operands and registered result.
- Flags divide-by-zero instead of passing the raw ALU quotient.
- Sits between the datapath issue logic and the ALU instance; one operation in flight at a time.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [M-1:0] req0_a,
    input  logic [M-1:0] req0_b,
    input  logic [3:0]   req0_sel,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [M-1:0] rsp0_result,
    output logic         rsp0_err,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [M-1:0] req1_a,
    input  logic [M-1:0] req1_b,
    input  logic [3:0]   req1_sel,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [M-1:0] rsp1_result,
    output logic         rsp1_err,

    output logic [M-1:0] alu_a,
    output logic [M-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [M-1:0] alu_out,

    output logic         busy
);

    localparam logic [3:0] SEL_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         ptr;
    logic         owner;
    logic [M-1:0] op_a;
    logic [M-1:0] op_b;
    logic [3:0]   op_sel;
    logic [M-1:0] result;
    logic         err;

    logic         grant_any;
    logic         grant_id;
    logic         rsp_take;

    // With a single requester valid the pointer is irrelevant; on a tie it decides.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid & req1_valid) ? ptr : ~req0_valid;
    end

    // Handshake outputs are gated by rst so nothing transfers in a reset cycle.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_take   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !rst) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner & ~rst;
                rsp1_valid = owner & ~rst;
                rsp_take   = owner ? rsp1_ready : rsp0_ready;
                if (rsp_take) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= 4'b0000;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_any) begin
                owner  <= grant_id;
                op_a   <= grant_id ? req1_a   : req0_a;
                op_b   <= grant_id ? req1_b   : req0_b;
                op_sel <= grant_id ? req1_sel : req0_sel;
            end
            // Divide-by-zero never forwards the ALU's raw quotient.
            if (state == EXEC) begin
                if (op_sel == SEL_DIV && op_b == '0) begin
                    result <= '1;
                    err    <= 1'b1;
                end else begin
                    result <= alu_out;
                    err    <= 1'b0;
                end
            end
            if (state == RESP && rsp_take) begin
                ptr <= ~owner;
            end
        end
    end

    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_sel = op_sel;

    // Result and flag are only ever visible on the owner's channel.
    assign rsp0_result = owner ? '0 : result;
    assign rsp1_result = owner ? result : '0;
    assign rsp0_err    = ~owner & err;
    assign rsp1_err    = owner & err;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a transaction-level reference model
module tb_alu_arbiter;

    localparam int M = 32;

    typedef struct packed {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [3:0]   sel;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [M-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_sel = '0, req1_sel = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [M-1:0] rsp0_result, rsp1_result;
    logic         rsp0_err, rsp1_err;
    logic [M-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         busy;

    always #5 clk = ~clk;

    // External ALU; divide by zero returns junk so the arbiter's override is visible.
    function automatic logic [M-1:0] alu_fn(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 0) ? 32'h0BAD_0BAD : a / b;
            4'd4:    return (b == 0) ? a : a % b;
            4'd5:    return a | b;
            4'd6:    return a & b;
            4'd7:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return ~a;
            4'd11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

    alu_arbiter #(.M(M)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: pending requester queues, one in-flight transaction record, a fairness pointer.
    op_t          q0[$], q1[$];
    op_t          cur[2];
    bit           v[2] = '{0, 0};
    bit           rr[2];
    int           rr_mode = 1;
    bit           dense = 1;
    int           cyc = 0;
    bit           pend = 0;
    int           p_owner, p_acc;
    op_t          p_op;
    logic [M-1:0] p_res;
    bit           p_err;
    int           ptr = 0;
    int           grant_log[$];
    logic [M-1:0] res_log[$];
    bit           err_log[$];

    function automatic op_t mk(input logic [M-1:0] a, input logic [M-1:0] b, input logic [3:0] sel);
        op_t o;
        o.a = a;
        o.b = b;
        o.sel = sel;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.a   = ($urandom_range(0, 3) == 0) ? M'($urandom_range(0, 15)) : M'($urandom);
        o.b   = ($urandom_range(0, 3) == 0) ? '0 : M'($urandom_range(0, 300));
        o.sel = 4'($urandom_range(0, 15));
        return o;
    endfunction

    task automatic step(input bit do_rst);
        int g;
        bit take;
        logic [M-1:0] got_res;
        @(negedge clk);
        rst = do_rst;
        if (!v[0] && q0.size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
            cur[0] = q0.pop_front();
            v[0] = 1;
        end
        if (!v[1] && q1.size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
            cur[1] = q1.pop_front();
            v[1] = 1;
        end
        req0_valid = v[0];
        req0_a     = v[0] ? cur[0].a   : M'($urandom);
        req0_b     = v[0] ? cur[0].b   : M'($urandom);
        req0_sel   = v[0] ? cur[0].sel : 4'($urandom);
        req1_valid = v[1];
        req1_a     = v[1] ? cur[1].a   : M'($urandom);
        req1_b     = v[1] ? cur[1].b   : M'($urandom);
        req1_sel   = v[1] ? cur[1].sel : 4'($urandom);
        for (int i = 0; i < 2; i++)
            rr[i] = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        rsp0_ready = rr[0];
        rsp1_ready = rr[1];
        #1;
        g = -1;
        take = 0;
        got_res = '0;
        if (do_rst) begin
            chk("rst_cycle_hs", 64'({req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 64'd0);
        end else if (!pend) begin
            if (v[0] && v[1]) g = ptr;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
            chk("idle_ready", 64'({req1_ready, req0_ready}), (g < 0) ? 64'd0 : (g == 0) ? 64'd1 : 64'd2);
            chk("idle_busy_rsp", 64'({busy, rsp1_valid, rsp0_valid}), 64'd0);
        end else if (cyc == p_acc + 1) begin
            chk("exec_hs", 64'({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 64'b10000);
            chk("exec_alu_a", 64'(alu_a), 64'(p_op.a));
            chk("exec_alu_b", 64'(alu_b), 64'(p_op.b));
            chk("exec_alu_sel", 64'(alu_sel), 64'(p_op.sel));
        end else begin
            chk("resp_hs", 64'({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}),
                (p_owner == 0) ? 64'b10001 : 64'b10010);
            got_res = (p_owner == 0) ? rsp0_result : rsp1_result;
            chk("resp_result", 64'(got_res), 64'(p_res));
            chk("resp_err", 64'((p_owner == 0) ? rsp0_err : rsp1_err), 64'(p_err));
            take = rr[p_owner];
        end
        @(posedge clk);
        if (do_rst) begin
            pend = 0;
            ptr = 0;
        end else if (g >= 0) begin
            pend = 1;
            p_owner = g;
            p_acc = cyc;
            p_op = cur[g];
            v[g] = 0;
            grant_log.push_back(g);
            p_err = (p_op.sel == 4'b0011 && p_op.b == 0);
            p_res = p_err ? '1 : alu_fn(p_op.a, p_op.b, p_op.sel);
        end else if (take) begin
            pend = 0;
            ptr = 1 - p_owner;
            res_log.push_back(got_res);
            err_log.push_back(p_err);
        end
        cyc++;
        if (do_rst) begin
            #1;
            chk("rst_state", 64'({busy, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, req1_ready, req0_ready}), 64'd0);
            chk("rst_alu_a", 64'(alu_a), 64'd0);
            chk("rst_alu_b", 64'(alu_b), 64'd0);
            chk("rst_alu_sel", 64'(alu_sel), 64'd0);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || v[0] || v[1] || pend) && n < budget) begin
            step(0);
            n++;
        end
        chk("drain_timeout", 64'(n >= budget), 64'd0);
    endtask

    function automatic logic [M-1:0] last_res();
        return (res_log.size() > 0) ? res_log[res_log.size() - 1] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int n;
        step(1);
        step(1);

        // Single request: latency and simple add.
        q0.push_back(mk(5, 7, 4'b0000));
        drain(20);
        chk("t1_result", 64'(last_res()), 64'd12);

        // Simultaneous requests after reset alternate 0,1,0,1.
        step(1);
        grant_log.delete();
        res_log.delete();
        q0.push_back(mk(9, 4, 4'b0001));
        q1.push_back(mk(3, 6, 4'b0010));
        q0.push_back(mk(11, 2, 4'b0000));
        q1.push_back(mk(4, 4, 4'b0010));
        drain(40);
        chk("t2_order", 64'((grant_log.size() == 4) ?
            {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]} : 4'hF), 64'b0101);
        chk("t2_first", 64'((res_log.size() >= 2) ? res_log[0] : '0), 64'd5);
        chk("t2_second", 64'((res_log.size() >= 2) ? res_log[1] : '0), 64'd18);

        // Divide by zero then a normal divide.
        q1.push_back(mk(100, 0, 4'b0011));
        drain(20);
        chk("t3_div0_result", 64'(last_res()), 64'hFFFF_FFFF);
        chk("t3_div0_err", 64'(err_log[err_log.size() - 1]), 64'd1);
        q1.push_back(mk(100, 7, 4'b0011));
        drain(20);
        chk("t3_div_result", 64'(last_res()), 64'd14);
        chk("t3_div_err", 64'(err_log[err_log.size() - 1]), 64'd0);

        // Backpressure on requester 0 while requester 1 waits.
        rr_mode = 2;
        q0.push_back(mk(20, 22, 4'b0000));
        n = 0;
        while (!(pend && cyc >= p_acc + 2) && n < 20) begin
            step(0);
            n++;
        end
        chk("t4_reach_resp", 64'(n >= 20), 64'd0);
        q1.push_back(mk(8, 3, 4'b0001));
        for (int i = 0; i < 5; i++) step(0);
        rr_mode = 1;
        grant_log.delete();
        drain(20);
        chk("t4_next_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd1);

        // Reset during EXEC discards the operation.
        q0.push_back(mk(50, 60, 4'b0000));
        n = 0;
        while (!pend && n < 20) begin
            step(0);
            n++;
        end
        chk("t5_accept", 64'(pend), 64'd1);
        res_log.delete();
        step(1);
        for (int i = 0; i < 4; i++) step(0);
        chk("t5_no_rsp", 64'(res_log.size()), 64'd0);
        q0.push_back(mk(1, 1, 4'b0110));
        drain(20);
        chk("t5_result", 64'(last_res()), 64'd1);

        // Undefined select passes through as add.
        q0.push_back(mk(2, 3, 4'b1111));
        drain(20);
        chk("t6_result", 64'(last_res()), 64'd5);
        chk("t6_err", 64'(err_log[err_log.size() - 1]), 64'd0);

        // Random traffic with random backpressure and sparse requests.
        rr_mode = 0;
        dense = 0;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        drain(6000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
